fetch_align_buffer: RTL and testbench

FETCH_ALIGN_BUFFER -- requirements
Module: fetch_align_buffer

---
 rtl/fetch_align_buffer.sv | 115 +++++++++++
 tb/tb_fetch_align_buffer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align_buffer.sv
// Fetch alignment buffer: a circular queue of 16-bit halfwords. It takes 32-bit
// fetch words and presents one whole instruction (compact or 32-bit) with its PC.
module fetch_align_buffer #(
  parameter int                    DEPTH_HW   = 8,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_valid,
  input  logic [31:0]           fetch_data,
  output logic                  fetch_ready,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic                  instr_is_compact,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc
);

  localparam int PW = $clog2(DEPTH_HW);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_LIMIT = CW'(DEPTH_HW - 2);

  logic [15:0]           mem_q [DEPTH_HW];
  logic [15:0]           mem_d [DEPTH_HW];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  skip_low_q, skip_low_d;

  logic [15:0]   h0, h1;
  logic          head_compact;
  logic          push, pop;
  logic [CW-1:0] push_hw, pop_hw;

  // Head decode; anything derived from the storage array is qualified by count.
  always_comb begin
    h0           = mem_q[rd_ptr_q];
    h1           = mem_q[rd_ptr_q + PW'(1)];
    head_compact = (h0[1:0] != 2'b11);
    fetch_ready  = (count_q <= READY_LIMIT);
    instr_valid  = head_compact ? (count_q >= CW'(1)) : (count_q >= CW'(2));
    instr_is_compact = head_compact && (count_q != '0);
    instr        = '0;
    if (instr_valid) begin
      instr = head_compact ? {16'h0000, h0} : {h1, h0};
    end
    instr_pc = pc_q;
    push     = fetch_valid && fetch_ready;
    pop      = instr_valid && instr_ready;
  end

  always_comb begin
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_d       = pc_q;
    skip_low_d = skip_low_q;
    push_hw    = '0;
    pop_hw     = '0;
    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      pc_d       = flush_pc;
      skip_low_d = flush_pc[1];
    end else begin
      // A redirect into the upper half of a word drops that word's low halfword.
      if (push) begin
        if (skip_low_q) begin
          mem_d[wr_ptr_q] = fetch_data[31:16];
          wr_ptr_d        = wr_ptr_q + PW'(1);
          skip_low_d      = 1'b0;
          push_hw         = CW'(1);
        end else begin
          mem_d[wr_ptr_q]          = fetch_data[15:0];
          mem_d[wr_ptr_q + PW'(1)] = fetch_data[31:16];
          wr_ptr_d                 = wr_ptr_q + PW'(2);
          push_hw                  = CW'(2);
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (head_compact ? PW'(1) : PW'(2));
        pc_d     = pc_q + (head_compact ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
        pop_hw   = head_compact ? CW'(1) : CW'(2);
      end
      count_d = count_q + push_hw - pop_hw;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pc_q       <= RESET_PC;
      skip_low_q <= RESET_PC[1];
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      skip_low_q <= skip_low_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer at default parameters (8 halfwords, 32-bit PC, RESET_PC 0).
module tb_fetch_align_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_data;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_is_compact;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        flush;
  logic [31:0] flush_pc;

  int checks = 0;
  int errors = 0;

  fetch_align_buffer dut (
    .clock            (clock),
    .reset            (reset),
    .fetch_valid      (fetch_valid),
    .fetch_data       (fetch_data),
    .fetch_ready      (fetch_ready),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_is_compact (instr_is_compact),
    .instr_pc         (instr_pc),
    .instr_ready      (instr_ready),
    .flush            (flush),
    .flush_pc         (flush_pc)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    tick();
    flush    = 1'b0;
  endtask

  initial begin
    reset       = 1'b0;
    fetch_valid = 1'b0;
    fetch_data  = '0;
    instr_ready = 1'b0;
    flush       = 1'b0;
    flush_pc    = '0;
    #1;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", instr_pc, 32'h0);
    check("rst_compact", 32'(instr_is_compact), 32'd0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    tick();
    tick();
    reset = 1'b1;

    // Single 32-bit instruction, consumed right away
    instr_ready = 1'b1;
    fetch_valid = 1'b1;
    fetch_data  = 32'h00A00093;
    tick();
    fetch_valid = 1'b0;
    check("addi_valid", 32'(instr_valid), 32'd1);
    check("addi_instr", instr, 32'h00A00093);
    check("addi_compact", 32'(instr_is_compact), 32'd0);
    check("addi_pc", instr_pc, 32'h0);
    tick();
    check("addi_pop_pc", instr_pc, 32'h4);
    check("addi_pop_valid", 32'(instr_valid), 32'd0);

    // Two compact instructions in one word
    do_flush(32'h0);
    fetch_valid = 1'b1;
    fetch_data  = 32'h45014505;
    tick();
    fetch_valid = 1'b0;
    check("cli0_instr", instr, 32'h00004505);
    check("cli0_pc", instr_pc, 32'h0);
    check("cli0_compact", 32'(instr_is_compact), 32'd1);
    tick();
    check("cli1_instr", instr, 32'h00004501);
    check("cli1_pc", instr_pc, 32'h2);
    check("cli1_compact", 32'(instr_is_compact), 32'd1);
    tick();
    check("cli_empty_valid", 32'(instr_valid), 32'd0);
    check("cli_empty_pc", instr_pc, 32'h4);

    // 32-bit instruction split across two fetch words
    instr_ready = 1'b0;
    do_flush(32'h0);
    fetch_valid = 1'b1;
    fetch_data  = 32'h00934505;
    tick();
    fetch_valid = 1'b0;
    check("split_cli_instr", instr, 32'h00004505);
    check("split_cli_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("split_half_valid", 32'(instr_valid), 32'd0);
    check("split_half_compact", 32'(instr_is_compact), 32'd0);
    check("split_half_pc", instr_pc, 32'h2);
    fetch_valid = 1'b1;
    fetch_data  = 32'h123400A0;
    tick();
    fetch_valid = 1'b0;
    check("split_full_valid", 32'(instr_valid), 32'd1);
    check("split_full_instr", instr, 32'h00A00093);
    check("split_full_pc", instr_pc, 32'h2);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("split_next_instr", instr, 32'h00001234);
    check("split_next_pc", instr_pc, 32'h6);

    // Flush to an upper-halfword target while holding three halfwords
    fetch_valid = 1'b1;
    fetch_data  = 32'hABCDEF01;
    tick();
    fetch_data  = 32'hFFFFFFFF;
    do_flush(32'h102);
    fetch_valid = 1'b0;
    check("flush_valid", 32'(instr_valid), 32'd0);
    check("flush_pc", instr_pc, 32'h102);
    check("flush_fetch_ready", 32'(fetch_ready), 32'd1);
    fetch_valid = 1'b1;
    fetch_data  = 32'h45051234;
    tick();
    fetch_valid = 1'b0;
    check("skip_valid", 32'(instr_valid), 32'd1);
    check("skip_instr", instr, 32'h00004505);
    check("skip_pc", instr_pc, 32'h102);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("skip_drain_valid", 32'(instr_valid), 32'd0);
    check("skip_drain_pc", instr_pc, 32'h104);

    // Fill to capacity, then drain with back-pressure observed
    do_flush(32'h0);
    fetch_valid = 1'b1;
    fetch_data  = 32'h45014505;
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", 32'(fetch_ready), 32'd1);
      tick();
    end
    check("full_fetch_ready", 32'(fetch_ready), 32'd0);
    fetch_data = 32'hDEADBEEF;
    tick();
    check("full_hold_ready", 32'(fetch_ready), 32'd0);
    check("full_hold_instr", instr, 32'h00004505);
    instr_ready = 1'b1;
    tick();
    check("pop1_fetch_ready", 32'(fetch_ready), 32'd0);
    check("pop1_pc", instr_pc, 32'h2);
    tick();
    fetch_valid = 1'b0;
    instr_ready = 1'b0;
    check("pop2_fetch_ready", 32'(fetch_ready), 32'd1);
    check("pop2_pc", instr_pc, 32'h4);
    check("pop2_instr", instr, 32'h00004505);

    // Simultaneous push and pop: count 6 + 2 - 1 = 7
    fetch_valid = 1'b1;
    fetch_data  = 32'h45014505;
    instr_ready = 1'b1;
    tick();
    fetch_valid = 1'b0;
    instr_ready = 1'b0;
    check("pushpop_fetch_ready", 32'(fetch_ready), 32'd0);
    check("pushpop_pc", instr_pc, 32'h6);
    check("pushpop_instr", instr, 32'h00004501);

    // Asynchronous reset mid-stream
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(instr_valid), 32'd0);
    check("async_rst_pc", instr_pc, 32'h0);
    check("async_rst_fetch_ready", 32'(fetch_ready), 32'd1);
    check("async_rst_compact", 32'(instr_is_compact), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_valid", 32'(instr_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
